note_sequencer: RTL and testbench
=================================

# note_sequencer

Parametrised chord recorder/player for the guitar front end: samples NUM_STRINGS string contacts and NUM_FRETS fret bars over one tempo window, encodes the window into a one-hot-per-(string, fret) note word, and stores it in a DEPTH-entry sequence memory. It replays the stored sequence at a programmable tempo, once or looped. It sits between the debounced GPIO inputs and the audio/display consumers. It replaces the fixed 6×4/64-entry record path with explicit length tracking, auto-stop on full, and loop playback.

## Interface
- NUM_STRINGS, 6, number of string inputs
- NUM_FRETS, 4, number of fret bars (fret 0 = open, implicit)
- DEPTH, 64, sequence memory entries (≥2)
- PERIOD_W, 27, width of tick_period
- Derived: NW = NUM_STRINGS*(NUM_FRETS+1) note width; AW = clog2(DEPTH+1)
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- cmd_record  in  1  one-cycle pulse: start recording from entry 0
- cmd_play  in  1  one-cycle pulse: start playback from entry 0
- cmd_stop  in  1  one-cycle pulse: return to IDLE
- loop_en  in  1  1 = wrap playback at end of sequence
- tick_period  in  PERIOD_W  clk cycles per note window; values <2 treated as 2
- strings  in  NUM_STRINGS  string contacts, 1 = struck
- frets  in  NUM_FRETS  fret bars, bit k = fret k+1 pressed
- note_out  out  NW  last recorded/played note word
- note_valid  out  1  one-cycle strobe when note_out updates
- length  out  AW  number of valid stored entries (0..DEPTH)
- addr  out  AW  current write/read entry index
- state  out  2  00 IDLE, 01 RECORDING, 10 PLAYING
- full  out  1  sticky: last recording stopped at DEPTH entries

## Operation
- FSM: IDLE, RECORDING, PLAYING. Command priority: cmd_stop > cmd_record > cmd_play.
- IDLE: cmd_record → RECORDING, addr=0, length=0, full=0. cmd_play with length>0 → PLAYING, addr=0; with length=0 ignored.
- RECORDING/PLAYING: cmd_record/cmd_play ignored; cmd_stop → IDLE next cycle.
- Tick counter: loaded with tick_period−1 on entry to RECORDING/PLAYING; decrements; tick when 0, then reloads with the current tick_period−1.
- Capture (RECORDING): string_acc |= strings each cycle; fret_acc = max(fret_acc, highest pressed fret index, 0 if none). Both clear on tick and on entry.
- Encode: bit s + NUM_STRINGS*f = string_acc[s] & (fret_acc==f), f=0..NUM_FRETS; all other bits 0. Fret precedence: highest fret wins.
- Record tick: mem[addr] ← encoded word (including accumulator state of the tick cycle); note_out ← same word; addr++, length++. If length reaches DEPTH → IDLE, full=1.
- Stop mid-window in RECORDING: partial window discarded; length keeps completed entries.
- Play tick: note_out ← mem[addr]. If addr==length−1: loop_en=1 → addr=0; else → IDLE. Otherwise addr++.
- loop_en is sampled at each last-entry tick.
- Memory contents are not reset. They are only read below length.

## Timing
- Reset: state=IDLE, note_out=0, note_valid=0, length=0, addr=0, full=0, accumulators=0, counter=0.
- Command accepted in cycle c → state changes at c+1.
- First tick occurs tick_period cycles after the entry edge.
- note_out/note_valid register at tick+1. note_valid is high exactly one cycle per tick; note_out holds between ticks.
- Auto-stop (full or end of non-loop play): state=IDLE in the same cycle note_valid is high.
- cmd_stop coincident with a tick: stop wins, no write, no note_valid.
- tick_period change mid-run takes effect at the next reload.
- Reset mid-operation: all state returns to reset values next cycle; length=0, so stored data is abandoned.

## Test plan
- Defaults, tick_period=10: cmd_record; hold strings=6'b000001, frets=0 for window 1; then strings=6'b000010, frets=4'b0011 for window 2; cmd_stop → length=2; note_valid at cycles 11 and 21 after entry; note_out=bit0, then bit 1+6*2=13.
- Continue: cmd_play, loop_en=0 → note_valid twice with the same words, then state=IDLE at second strobe; addr returns ≤length−1.
- DEPTH=4, record with no stop → state=IDLE, full=1, length=4 after 4th tick; cmd_play, loop_en=1 → words repeat 0,1,2,3,0,1… for 10 ticks.
- cmd_play with length=0 → state stays IDLE, no note_valid. cmd_record and cmd_play in the same cycle → RECORDING.
- cmd_stop on a tick cycle during record → no write, length unchanged. tick_period=1 → strobes every 2 cycles.
- resetn low for 1 cycle during PLAYING → next cycle all outputs 0, state=IDLE; subsequent cmd_play is ignored.

Source files
------------

// File: rtl/note_sequencer.sv
// Chord recorder/player: accumulates string/fret contacts over one tempo window,
// stores one note word per window, and replays the sequence once or looped.
module note_sequencer #(
    parameter  int NUM_STRINGS = 6,
    parameter  int NUM_FRETS   = 4,
    parameter  int DEPTH       = 64,
    parameter  int PERIOD_W    = 27,
    localparam int NW          = NUM_STRINGS * (NUM_FRETS + 1),
    localparam int AW          = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cmd_record,
    input  logic                   cmd_play,
    input  logic                   cmd_stop,
    input  logic                   loop_en,
    input  logic [PERIOD_W-1:0]    tick_period,
    input  logic [NUM_STRINGS-1:0] strings,
    input  logic [NUM_FRETS-1:0]   frets,
    output logic [NW-1:0]          note_out,
    output logic                   note_valid,
    output logic [AW-1:0]          length,
    output logic [AW-1:0]          addr,
    output logic [1:0]             state,
    output logic                   full
);

    localparam int FW = $clog2(NUM_FRETS + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RECORDING = 2'b01,
        PLAYING   = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic [PERIOD_W-1:0]    cnt_q, cnt_d;
    logic [NUM_STRINGS-1:0] str_acc_q, str_acc_d;
    logic [FW-1:0]          fret_acc_q, fret_acc_d;
    logic [NW-1:0]          note_q, note_d;
    logic                   valid_q, valid_d;
    logic [AW-1:0]          len_q, len_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic                   full_q, full_d;

    logic [NW-1:0]          mem [DEPTH];
    logic                   mem_we;

    logic [PERIOD_W-1:0]    reload;
    logic [NUM_STRINGS-1:0] str_now;
    logic [FW-1:0]          fret_in;
    logic [FW-1:0]          fret_now;
    logic [NW-1:0]          word;
    logic                   tick;

    // Periods below two would leave no room for the reload cycle.
    assign reload = (tick_period < PERIOD_W'(2)) ? PERIOD_W'(1) : tick_period - PERIOD_W'(1);
    assign tick   = (state_q != IDLE) && (cnt_q == '0);

    // Encoder sees the tick cycle's own contacts so the window is complete.
    always_comb begin
        fret_in = '0;
        for (int k = 0; k < NUM_FRETS; k++) begin
            if (frets[k]) fret_in = FW'(k + 1);
        end
        str_now  = str_acc_q | strings;
        fret_now = (fret_in > fret_acc_q) ? fret_in : fret_acc_q;
        word     = '0;
        for (int s = 0; s < NUM_STRINGS; s++) begin
            for (int f = 0; f <= NUM_FRETS; f++) begin
                word[s + NUM_STRINGS * f] = str_now[s] & (fret_now == FW'(f));
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        str_acc_d  = str_acc_q;
        fret_acc_d = fret_acc_q;
        note_d     = note_q;
        valid_d    = 1'b0;
        len_d      = len_q;
        addr_d     = addr_q;
        full_d     = full_q;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                end else if (cmd_record) begin
                    state_d    = RECORDING;
                    addr_d     = '0;
                    len_d      = '0;
                    full_d     = 1'b0;
                    cnt_d      = reload;
                    str_acc_d  = '0;
                    fret_acc_d = '0;
                end else if (cmd_play && (len_q != '0)) begin
                    state_d = PLAYING;
                    addr_d  = '0;
                    cnt_d   = reload;
                end
            end

            RECORDING: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    mem_we     = 1'b1;
                    note_d     = word;
                    valid_d    = 1'b1;
                    addr_d     = addr_q + AW'(1);
                    len_d      = len_q + AW'(1);
                    cnt_d      = reload;
                    str_acc_d  = '0;
                    fret_acc_d = '0;
                    if (len_q == AW'(DEPTH - 1)) begin
                        state_d = IDLE;
                        full_d  = 1'b1;
                    end
                end else begin
                    cnt_d      = cnt_q - PERIOD_W'(1);
                    str_acc_d  = str_now;
                    fret_acc_d = fret_now;
                end
            end

            PLAYING: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    note_d  = mem[addr_q[IW-1:0]];
                    valid_d = 1'b1;
                    cnt_d   = reload;
                    if (addr_q == len_q - AW'(1)) begin
                        if (loop_en) addr_d  = '0;
                        else         state_d = IDLE;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            str_acc_q  <= '0;
            fret_acc_q <= '0;
            note_q     <= '0;
            valid_q    <= 1'b0;
            len_q      <= '0;
            addr_q     <= '0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            str_acc_q  <= str_acc_d;
            fret_acc_q <= fret_acc_d;
            note_q     <= note_d;
            valid_q    <= valid_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            full_q     <= full_d;
        end
    end

    // NOTE: the sequence memory has no reset; entries at or above length are never read.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q[IW-1:0]] <= word;
    end

    assign note_out   = note_q;
    assign note_valid = valid_q;
    assign length     = len_q;
    assign addr       = addr_q;
    assign state      = state_q;
    assign full       = full_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: driver pushes expected strobes into a
// scoreboard queue, a negedge monitor pops and compares on every note_valid.
module tb_note_sequencer;

    localparam int NS = 6;
    localparam int NF = 4;
    localparam int D  = 4;
    localparam int PW = 27;
    localparam int NW = NS * (NF + 1);
    localparam int AW = $clog2(D + 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_REC  = 2'b01;
    localparam logic [1:0] S_PLAY = 2'b10;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cmd_record = 1'b0;
    logic          cmd_play = 1'b0;
    logic          cmd_stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [PW-1:0] tick_period = PW'(10);
    logic [NS-1:0] strings = '0;
    logic [NF-1:0] frets = '0;
    logic [NW-1:0] note_out;
    logic          note_valid;
    logic [AW-1:0] length;
    logic [AW-1:0] addr;
    logic [1:0]    state;
    logic          full;

    note_sequencer #(
        .NUM_STRINGS(NS),
        .NUM_FRETS  (NF),
        .DEPTH      (D),
        .PERIOD_W   (PW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_record (cmd_record),
        .cmd_play   (cmd_play),
        .cmd_stop   (cmd_stop),
        .loop_en    (loop_en),
        .tick_period(tick_period),
        .strings    (strings),
        .frets      (frets),
        .note_out   (note_out),
        .note_valid (note_valid),
        .length     (length),
        .addr       (addr),
        .state      (state),
        .full       (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] word;
        logic [1:0]    st;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    logic [NW-1:0] m_mem [D];
    int            m_len = 0;
    int            n_cmp = 0;
    int            n_fail = 0;
    int            ncyc = 0;
    logic [NS-1:0] fix_s [2] = '{6'b000001, 6'b000010};
    logic [NF-1:0] fix_f [2] = '{4'b0000, 4'b0011};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one negedge per cycle; every strobe must match the head of the queue.
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (note_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: got note_out %0h with no expected strobe (t=%0t)", note_out, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("strobe_word", note_out, e.word);
                check("strobe_state", state, e.st);
                check("strobe_cycle", ncyc, e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int hi_fret(input logic [NF-1:0] f);
        for (int k = NF - 1; k >= 0; k--) begin
            if (f[k]) return k + 1;
        end
        return 0;
    endfunction

    function automatic logic [NW-1:0] encode(input logic [NS-1:0] s_acc, input int fr);
        logic [NW-1:0] w;
        w = '0;
        for (int s = 0; s < NS; s++) begin
            if (s_acc[s]) w[s + NS * fr] = 1'b1;
        end
        return w;
    endfunction

    function automatic logic [NS-1:0] rand_s();
        return NS'($urandom() & $urandom());
    endfunction

    function automatic logic [NF-1:0] rand_f();
        return NF'($urandom() & $urandom() & $urandom());
    endfunction

    task automatic do_cycle(input logic [NS-1:0] s, input logic [NF-1:0] f, input logic stop);
        #1;
        resetn = 1'b1; cmd_record = 1'b0; cmd_play = 1'b0; cmd_stop = stop;
        strings = s; frets = f;
        @(posedge clk);
    endtask

    // Returns the monitor cycle number of the first cycle after the accepting edge.
    task automatic issue_cmd(input logic rec, input logic play, input int tp, output int entry);
        #1;
        resetn = 1'b1; cmd_record = rec; cmd_play = play; cmd_stop = 1'b0;
        tick_period = PW'(tp); strings = rand_s(); frets = rand_f();
        @(posedge clk);
        entry = ncyc + 1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    task automatic rec_phase(input int tp, input int nwin, input bit fixed, input bit both, input int stop_at);
        int            entry;
        int            p;
        int            fm;
        logic [NS-1:0] s;
        logic [NS-1:0] sa;
        logic [NF-1:0] f;
        exp_t          e;
        p = (tp < 2) ? 2 : tp;
        issue_cmd(1'b1, both, tp, entry);
        m_len = 0;
        if (both) begin
            @(negedge clk);
            check("record_beats_play", state, S_REC);
        end
        for (int w = 1; w <= nwin; w++) begin
            sa = '0;
            fm = 0;
            for (int k = 1; k <= p; k++) begin
                if (fixed) begin s = fix_s[w-1]; f = fix_f[w-1]; end
                else       begin s = rand_s();   f = rand_f();   end
                sa |= s;
                if (hi_fret(f) > fm) fm = hi_fret(f);
                do_cycle(s, f, 1'b0);
            end
            e.word = encode(sa, fm);
            m_mem[m_len] = e.word;
            m_len++;
            e.st  = (m_len == D) ? S_IDLE : S_REC;
            e.cyc = entry + w * p;
            sb_q.push_back(e);
            if (m_len == D) break;
        end
        if (m_len < D) begin
            for (int k = 1; k < stop_at; k++) do_cycle(rand_s(), rand_f(), 1'b0);
            do_cycle(rand_s(), rand_f(), 1'b1);
        end
        drain();
        check("rec_end_state", state, S_IDLE);
        check("rec_length", length, m_len);
        check("rec_full", full, (m_len == D));
    endtask

    task automatic play_phase(input int tp, input bit lp, input int nt);
        int   entry;
        int   p;
        int   n;
        exp_t e;
        p = (tp < 2) ? 2 : tp;
        loop_en = lp;
        issue_cmd(1'b0, 1'b1, tp, entry);
        n = lp ? nt : m_len;
        for (int k = 1; k <= n; k++) begin
            e.word = m_mem[(k - 1) % m_len];
            e.st   = (!lp && k == n) ? S_IDLE : S_PLAY;
            e.cyc  = entry + k * p;
            sb_q.push_back(e);
        end
        for (int k = 1; k <= n * p; k++) do_cycle(rand_s(), rand_f(), 1'b0);
        if (lp) do_cycle(rand_s(), rand_f(), 1'b1);
        drain();
        check("play_end_state", state, S_IDLE);
        if (!lp) check("play_addr_in_range", (addr < length), 1'b1);
    endtask

    initial begin
        int entry;
        int p;
        exp_t e;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_note_out", note_out, 0);
        check("reset_note_valid", note_valid, 0);
        check("reset_length", length, 0);
        check("reset_addr", addr, 0);
        check("reset_state", state, S_IDLE);
        check("reset_full", full, 0);

        // Play with an empty sequence is ignored.
        issue_cmd(1'b0, 1'b1, 10, entry);
        repeat (4) do_cycle(rand_s(), rand_f(), 1'b0);
        @(negedge clk);
        check("empty_play_ignored", state, S_IDLE);

        // Two held windows, then stop mid-window three.
        rec_phase(10, 2, 1'b1, 1'b0, 3);
        check("first_word_bit0", m_mem[0], encode(6'b000001, 0));
        check("last_note_out", note_out, NW'(1) << 13);
        check("rec_addr", addr, 2);
        play_phase(10, 1'b0, 0);

        // Fill the memory: auto-stop with full set, then looped playback.
        p = $urandom_range(2, 6);
        rec_phase(p, D, 1'b0, 1'b0, 0);
        play_phase(p, 1'b1, 10);

        // Record and play together: record wins. Stop lands on a tick.
        p = $urandom_range(2, 5);
        rec_phase(p, 2, 1'b0, 1'b1, p);

        // Period of one behaves as two.
        rec_phase(1, 3, 1'b0, 1'b0, 1);
        play_phase(1, 1'b0, 0);

        for (int it = 0; it < 3; it++) begin
            p = $urandom_range(2, 5);
            rec_phase(p, $urandom_range(1, 3), 1'b0, 1'b0, $urandom_range(1, p));
            play_phase(p, 1'b0, 0);
        end

        // Reset during looped playback abandons the sequence.
        p = 3;
        loop_en = 1'b1;
        issue_cmd(1'b0, 1'b1, p, entry);
        for (int k = 1; k <= 2; k++) begin
            e.word = m_mem[(k - 1) % m_len];
            e.st   = S_PLAY;
            e.cyc  = entry + k * p;
            sb_q.push_back(e);
        end
        for (int k = 1; k <= 2 * p; k++) do_cycle(rand_s(), rand_f(), 1'b0);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_note_out", note_out, 0);
        check("mid_reset_note_valid", note_valid, 0);
        check("mid_reset_length", length, 0);
        check("mid_reset_addr", addr, 0);
        check("mid_reset_state", state, S_IDLE);
        check("mid_reset_full", full, 0);
        check("mid_reset_drained", sb_q.size(), 0);
        issue_cmd(1'b0, 1'b1, p, entry);
        repeat (2 * p) do_cycle(rand_s(), rand_f(), 1'b0);
        @(negedge clk);
        check("play_after_reset_ignored", state, S_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
